// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared dmem types: DMType encodings, arbiter states, defaults
package dmem_arbiter_pkg;

  typedef enum logic [2:0] {
    DM_LB  = 3'd0,
    DM_LH  = 3'd1,
    DM_LW  = 3'd2,
    DM_LBU = 3'd3,
    DM_LHU = 3'd4
  } dmtype_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_RESP = 1'b1
  } arb_state_e;

  localparam int unsigned STARVE_LIMIT_DEF = 1024;

endpackage

// File: rtl/arb_starve_cnt.sv
// rtl/arb_starve_cnt.sv - saturating debug wait counter with sticky starvation flag
module arb_starve_cnt
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic gnt,
  input  logic clr,
  output logic starve
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_nxt;
  logic         set;

  always_comb begin
    cnt_nxt = cnt;
    if (!req || gnt) begin
      cnt_nxt = '0;
    end else if (cnt != W'(LIMIT)) begin
      cnt_nxt = cnt + 1'b1;
    end
    set = (cnt_nxt == W'(LIMIT));
  end

  // A coincident set beats the clear so a still-starving requester stays flagged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      starve <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      starve <= set | (starve & ~clr);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - dmem port arbiter, CPU has absolute priority over debug/loader
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_re,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_dmtype,
  output logic [31:0] cpu_rdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  input  logic [2:0]  dbg_dmtype,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic        starve,
  input  logic        starve_clr,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic [2:0]  mem_dmtype,
  input  logic [31:0] mem_rd
);

  arb_state_e state;
  arb_state_e state_nxt;
  logic       cpu_act;

  assign cpu_act    = cpu_re | cpu_we;
  assign cpu_rdata  = mem_rd;
  assign dbg_rvalid = (state == ARB_RESP);

  always_comb begin
    state_nxt  = state;
    dbg_gnt    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = cpu_addr;
    mem_wd     = cpu_wdata;
    mem_dmtype = cpu_dmtype;
    if (cpu_act) begin
      mem_we = cpu_we;
    end else if (state == ARB_IDLE && dbg_req) begin
      dbg_gnt    = 1'b1;
      mem_we     = dbg_we;
      mem_addr   = dbg_addr;
      mem_wd     = dbg_wdata;
      mem_dmtype = dbg_dmtype;
    end
    if (state == ARB_RESP) begin
      state_nxt = ARB_IDLE;
    end else if (dbg_gnt && !dbg_we) begin
      state_nxt = ARB_RESP;
    end
    // Reset must never let a stray write or grant reach the memory
    if (rst) begin
      dbg_gnt = 1'b0;
      mem_we  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB_IDLE;
      dbg_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (dbg_gnt && !dbg_we) begin
        dbg_rdata <= mem_rd;
      end
    end
  end

  arb_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .req    (dbg_req),
    .gnt    (dbg_gnt),
    .clr    (starve_clr),
    .starve (starve)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_re, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [2:0]  cpu_dmtype;
  logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic [2:0]  dbg_dmtype;
  logic        starve, starve_clr;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic [2:0]  mem_dmtype;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_re     (cpu_re),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_dmtype (cpu_dmtype),
    .cpu_rdata  (cpu_rdata),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_dmtype (dbg_dmtype),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .starve     (starve),
    .starve_clr (starve_clr),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_dmtype (mem_dmtype),
    .mem_rd     (mem_rd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    cpu_re = 1'b0; cpu_we = 1'b0;
    cpu_addr = 32'h0000_0010; cpu_wdata = 32'h0; cpu_dmtype = DM_LW;
    dbg_req = 1'b1; dbg_we = 1'b1;
    dbg_addr = 32'h0000_0020; dbg_wdata = 32'h5555_AAAA; dbg_dmtype = DM_LB;
    starve_clr = 1'b0; mem_rd = 32'h0;

    // Reset holds off grants and writes even with a pending debug write
    #3;
    check("rst_gnt", 32'(dbg_gnt), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_rvalid", 32'(dbg_rvalid), 32'd0);
    check("rst_rdata", dbg_rdata, 32'h0);
    check("rst_starve", 32'(starve), 32'd0);

    @(negedge clk);
    rst = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
    #1;
    check("idle_mem_we", 32'(mem_we), 32'd0);
    check("idle_mem_addr", mem_addr, 32'h0000_0010);

    // Debug read at 0x40, then a back-to-back read request held through RESP
    @(negedge clk);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h40; dbg_dmtype = DM_LHU;
    mem_rd = 32'hDEAD_BEEF;
    #1;
    check("rd_gnt", 32'(dbg_gnt), 32'd1);
    check("rd_mem_addr", mem_addr, 32'h40);
    check("rd_mem_we", 32'(mem_we), 32'd0);
    check("rd_dmtype", 32'(mem_dmtype), 32'(DM_LHU));
    check("rd_rvalid_early", 32'(dbg_rvalid), 32'd0);
    @(negedge clk);
    dbg_addr = 32'h44; mem_rd = 32'h1234_5678;
    #1;
    check("rd_rvalid", 32'(dbg_rvalid), 32'd1);
    check("rd_rdata", dbg_rdata, 32'hDEAD_BEEF);
    check("resp_no_gnt", 32'(dbg_gnt), 32'd0);
    @(negedge clk);
    #1;
    check("rd2_gnt", 32'(dbg_gnt), 32'd1);
    check("rd2_rvalid_low", 32'(dbg_rvalid), 32'd0);
    check("rd2_mem_addr", mem_addr, 32'h44);
    @(negedge clk);
    dbg_req = 1'b0; mem_rd = 32'h0;
    #1;
    check("rd2_rvalid", 32'(dbg_rvalid), 32'd1);
    check("rd2_rdata", dbg_rdata, 32'h1234_5678);
    @(negedge clk);
    #1;
    check("rvalid_one_cycle", 32'(dbg_rvalid), 32'd0);

    // CPU store collides with a debug write; debug waits one cycle
    @(negedge clk);
    cpu_we = 1'b1; cpu_addr = 32'h100; cpu_wdata = 32'hAA; cpu_dmtype = DM_LW;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h200; dbg_wdata = 32'hBB;
    mem_rd = 32'h7777_0000;
    #1;
    check("col_gnt", 32'(dbg_gnt), 32'd0);
    check("col_mem_addr", mem_addr, 32'h100);
    check("col_mem_wd", mem_wd, 32'hAA);
    check("col_mem_we", 32'(mem_we), 32'd1);
    check("col_cpu_rdata", cpu_rdata, 32'h7777_0000);
    @(negedge clk);
    cpu_we = 1'b0;
    #1;
    check("col_late_gnt", 32'(dbg_gnt), 32'd1);
    check("col_late_addr", mem_addr, 32'h200);
    check("col_late_wd", mem_wd, 32'hBB);
    check("col_late_we", 32'(mem_we), 32'd1);

    // Four back-to-back debug writes with the CPU idle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dbg_addr = 32'(i * 4); dbg_wdata = 32'hA0 + 32'(i);
      #1;
      check("wr_gnt", 32'(dbg_gnt), 32'd1);
      check("wr_mem_we", 32'(mem_we), 32'd1);
      check("wr_mem_addr", mem_addr, 32'(i * 4));
      check("wr_rvalid", 32'(dbg_rvalid), 32'd0);
    end
    @(negedge clk);
    dbg_req = 1'b0;
    #1;
    check("wr_after_rvalid", 32'(dbg_rvalid), 32'd0);
    check("wr_after_mem_we", 32'(mem_we), 32'd0);

    // CPU loads starve the debug port; flag sets after 8 wait cycles
    @(negedge clk);
    cpu_re = 1'b1; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h80;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      check("stv_flag", 32'(starve), (k >= 9) ? 32'd1 : 32'd0);
      check("stv_gnt", 32'(dbg_gnt), 32'd0);
    end
    @(negedge clk);
    starve_clr = 1'b1;
    #1;
    check("stv_hold", 32'(starve), 32'd1);
    @(negedge clk);
    cpu_re = 1'b0; dbg_req = 1'b0;
    #1;
    check("stv_set_wins", 32'(starve), 32'd1);
    @(negedge clk);
    starve_clr = 1'b0;
    #1;
    check("stv_cleared", 32'(starve), 32'd0);

    // Reset lands while a read response is pending
    @(negedge clk);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h90; mem_rd = 32'hCAFE_F00D;
    #1;
    check("rr_gnt", 32'(dbg_gnt), 32'd1);
    @(negedge clk);
    dbg_req = 1'b0;
    #1;
    check("rr_rvalid", 32'(dbg_rvalid), 32'd1);
    check("rr_rdata", dbg_rdata, 32'hCAFE_F00D);
    #1;
    rst = 1'b1; dbg_req = 1'b1; dbg_we = 1'b1;
    #1;
    check("rr_rvalid_rst", 32'(dbg_rvalid), 32'd0);
    check("rr_rdata_rst", dbg_rdata, 32'h0);
    check("rr_state_rst", 32'(dut.state), 32'(ARB_IDLE));
    check("rr_gnt_rst", 32'(dbg_gnt), 32'd0);
    check("rr_mem_we_rst", 32'(mem_we), 32'd0);
    @(negedge clk);
    rst = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
    #1;
    check("rr_no_rvalid0", 32'(dbg_rvalid), 32'd0);
    @(negedge clk);
    #1;
    check("rr_no_rvalid1", 32'(dbg_rvalid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 1024: dbg wait cycles, without grant, after which the starve flag sets.
REQ-002 SHALL have ports `clk` (input, 1): single clock, all state on rising edge.
REQ-003 SHALL have `rst` (input, 1): asynchronous, active-high reset.
REQ-004 SHALL have `cpu_re` (input, 1): CPU load access this cycle.
REQ-005 SHALL have `cpu_we` (input, 1): CPU store access this cycle.
REQ-006 SHALL have `cpu_addr` (32), `cpu_wdata` (32) and `cpu_dmtype` (3), all inputs: CPU access fields.
REQ-007 SHALL have `cpu_rdata` (output, 32): read data returned to the CPU, combinational from `mem_rd`.
REQ-008 SHALL have `dbg_req` (input, 1) and `dbg_we` (input, 1): debug/loader request and write qualifier.
REQ-009 SHALL have `dbg_addr` (32), `dbg_wdata` (32) and `dbg_dmtype` (3), all inputs: debug access fields.
REQ-010 SHALL have `dbg_gnt` (output, 1): request accepted this cycle.
REQ-011 SHALL have `dbg_rvalid` (output, 1) and `dbg_rdata` (output, 32): registered read response.
REQ-012 SHALL have `starve` (output, 1): sticky starvation flag.
REQ-013 SHALL have `starve_clr` (input, 1): synchronous clear of `starve`.
REQ-014 SHALL have `mem_we` (output, 1), `mem_addr` (32), `mem_wd` (32) and `mem_dmtype` (3): dmem port drive.
REQ-015 SHALL have `mem_rd` (input, 32): dmem combinational read data.

Function
REQ-016 SHALL give the CPU absolute priority: cpu_act = cpu_re | cpu_we; the CPU is never stalled.
REQ-017 SHALL, when cpu_act=1, drive the mem_* outputs from the cpu_* inputs (mem_we=cpu_we) with dbg_gnt=0.
REQ-018 SHALL implement FSM states IDLE and RESP, with reset state IDLE.
REQ-019 SHALL, in IDLE with dbg_req=1 and cpu_act=0, assert dbg_gnt combinationally and drive the mem_* outputs from the dbg_* inputs (mem_we=dbg_we).
REQ-020 SHALL, on a granted read, capture mem_rd into dbg_rdata at that clock edge and move to RESP.
REQ-021 SHALL, on a granted write, commit the write at the grant edge and remain in IDLE; no rvalid.
REQ-022 SHALL, in RESP, assert dbg_rvalid for exactly one cycle, hold dbg_gnt=0 (no back-to-back read grant), and return to IDLE.
REQ-023 SHALL allow back-to-back dbg writes, one per CPU-idle cycle.
REQ-024 SHALL, with no access active, drive mem_we=0 and mem_addr/mem_wd/mem_dmtype from the cpu_* inputs.
REQ-025 SHALL require the requester to hold dbg_req and all fields stable until dbg_gnt; deasserting dbg_req before grant withdraws the request with no side effect.
REQ-026 SHALL keep a wait counter that increments each cycle dbg_req=1 && dbg_gnt=0, clears on grant or on dbg_req=0, and saturates at STARVE_LIMIT.
REQ-027 SHALL set starve when the counter reaches STARVE_LIMIT, and hold it until starve_clr or rst; if set and clear coincide, the set wins.
REQ-028 SHALL pass dmtype unchanged; the arbiter does no alignment or byte-lane logic.
REQ-029 SHALL set cpu_rdata = mem_rd at all times; the CPU owns mem_rd in any cycle where cpu_act=1.

Reset
REQ-030 SHALL, on rst, asynchronously force: state=IDLE, dbg_rvalid=0, dbg_rdata=0, wait counter=0, starve=0.
REQ-031 SHALL, with rst asserted, hold dbg_gnt=0 and mem_we=0 regardless of inputs.
REQ-032 SHALL, on reset in RESP, drop the pending response with no later rvalid.

Structure
REQ-033 SHALL place the FSM state encoding (IDLE/RESP) and the default STARVE_LIMIT constant in the shared package with the existing DMType encodings.
REQ-034 SHALL implement the saturating wait counter plus sticky flag as sub-module arb_starve_cnt.
REQ-035 SHALL keep the total at roughly 150-250 RTL lines, with no other sub-modules.

Verification
REQ-036 SHALL check: cpu_act=0, dbg read at 0x40 (mem_rd=0xDEADBEEF) -> dbg_gnt that cycle, dbg_rvalid and dbg_rdata=0xDEADBEEF next cycle.
REQ-037 SHALL check: cpu_we=1 and dbg_req=1 in the same cycle -> mem_addr=cpu_addr, dbg_gnt=0; dbg granted the first cycle cpu_act=0.
REQ-038 SHALL check: 4 consecutive dbg writes 0x0..0xC with CPU idle -> 4 grants in 4 cycles, mem_we=1 each.
REQ-039 SHALL check: STARVE_LIMIT=8, cpu_re held 1 with dbg_req=1 for 10 cycles -> starve rises after 8 wait cycles, stays set until starve_clr.
REQ-040 SHALL check: rst asserted mid-cycle while in RESP -> dbg_rvalid=0 immediately, state IDLE, no later rvalid.
